// File: rtl/operand_entry.sv
// Operand entry front-end: synchronises and debounces the enter button, then
// steps through A / B / opcode capture. Debounce is built only when OPERAND_ENTRY_DEBOUNCE_EN is defined.
module operand_entry #(
    parameter int DB_LIMIT = 1000000,
    parameter int DB_W     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    output logic [3:0] A,
    output logic [3:0] B,
    // "type" is a reserved word in SystemVerilog, hence op_type.
    output logic       op_type,
    output logic [1:0] select,
    output logic       valid,
    output logic [1:0] phase,
    output logic       press
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        SHOW    = 2'b11
    } state_t;

    state_t     state, state_next;
    logic [3:0] a_next, b_next;
    logic       type_next, valid_next;
    logic [1:0] select_next;

    logic s1, s2;
    logic db_q, db_q_d;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_enter;
            s2 <= s1;
        end
    end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    logic [DB_W-1:0] db_cnt;

    // db_q only follows s2 after it has disagreed for DB_LIMIT consecutive edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_q   <= 1'b0;
            db_cnt <= '0;
        end else if (s2 == db_q) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_LIMIT - 1)) begin
            db_q   <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    localparam int unused_db_cfg = DB_LIMIT + DB_W;

    assign db_q = s2;
`endif

    always_ff @(posedge clk) begin
        if (reset) db_q_d <= 1'b0;
        else       db_q_d <= db_q;
    end

    assign press = db_q & ~db_q_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD_A;
            A       <= '0;
            B       <= '0;
            op_type <= 1'b0;
            select  <= '0;
            valid   <= 1'b0;
        end else begin
            state   <= state_next;
            A       <= a_next;
            B       <= b_next;
            op_type <= type_next;
            select  <= select_next;
            valid   <= valid_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        a_next      = A;
        b_next      = B;
        type_next   = op_type;
        select_next = select;
        valid_next  = valid;
        if (press) begin
            unique case (state)
                LOAD_A: begin
                    a_next     = sw;
                    state_next = LOAD_B;
                end
                LOAD_B: begin
                    b_next     = sw;
                    state_next = LOAD_OP;
                end
                LOAD_OP: begin
                    type_next   = sw[2];
                    select_next = sw[1:0];
                    valid_next  = 1'b1;
                    state_next  = SHOW;
                end
                SHOW: begin
                    valid_next = 1'b0;
                    state_next = LOAD_A;
                end
                default: state_next = LOAD_A;
            endcase
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: a small model pushes the expected outputs
// for each press, and they are popped and compared on the capture edge.
module tb_operand_entry;

    localparam int DB_LIMIT = 4;
    localparam int DB_W     = 3;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    localparam int LAT = DB_LIMIT + 3;
`else
    localparam int LAT = 3;
`endif

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       t;
        logic [1:0] sel;
        logic       valid;
        logic [1:0] phase;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw = 4'h0;
    logic       btn_enter = 1'b0;
    logic [3:0] A, B;
    logic       op_type;
    logic [1:0] select;
    logic       valid;
    logic [1:0] phase;
    logic       press;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   press_count = 0;
    obs_t m;
    obs_t sb[$];

    operand_entry #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) dut (
        .clk(clk), .reset(reset), .sw(sw), .btn_enter(btn_enter),
        .A(A), .B(B), .op_type(op_type), .select(select),
        .valid(valid), .phase(phase), .press(press)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (press === 1'b1) press_count++;

    function automatic obs_t observed();
        return '{a: A, b: B, t: op_type, sel: select, valid: valid, phase: phase};
    endfunction

    task automatic model_reset();
        m = '0;
    endtask

    task automatic apply_model(input logic [3:0] s);
        case (m.phase)
            2'b00: begin m.a = s; m.phase = 2'b01; end
            2'b01: begin m.b = s; m.phase = 2'b10; end
            2'b10: begin m.t = s[2]; m.sel = s[1:0]; m.valid = 1'b1; m.phase = 2'b11; end
            default: begin m.valid = 1'b0; m.phase = 2'b00; end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        btn_enter = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        sb.delete();
    endtask

    // One accepted press: btn high for 'hold' cycles, capture expected on edge LAT.
    task automatic enter(input logic [3:0] sw_val, input int hold);
        obs_t       exp_v, obs_v;
        logic [1:0] phase0;
        int         pc0;
        phase0 = m.phase;
        apply_model(sw_val);
        sb.push_back(m);
        @(negedge clk); #1;
        pc0 = press_count;
        sw = sw_val;
        btn_enter = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            @(negedge clk); #1;
            if (e == hold) btn_enter = 1'b0;
            if (e == LAT - 1) begin
                n_cmp++;
                if (press !== 1'b1 || phase !== phase0) begin
                    n_bad++;
                    $display("FAIL pre_capture sw=%h: press=%b phase=%b, expected press=1 phase=%b",
                             sw_val, press, phase, phase0);
                end
            end
            if (e == LAT) begin
                obs_v = observed();
                exp_v = (sb.size() > 0) ? sb.pop_front() : '1;
                n_cmp++;
                if (obs_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL capture sw=%h: got {A,B,t,sel,v,ph}=%h, expected %h",
                             sw_val, obs_v, exp_v);
                end
            end
        end
        for (int e = LAT + 1; e <= hold; e++) begin
            @(negedge clk); #1;
            if (e == hold) btn_enter = 1'b0;
        end
        repeat (LAT + 2) @(negedge clk);
        #1;
        n_cmp++;
        if (press_count - pc0 !== 1) begin
            n_bad++;
            $display("FAIL press_count sw=%h: got %0d pulses, expected 1", sw_val, press_count - pc0);
        end
    endtask

    task automatic test_reset();
        sw = 4'hF;
        btn_enter = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (observed() !== obs_t'(0) || press !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got %h press=%b, expected 0000 press=0", observed(), press);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_glitch();
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
        int pc0;
        @(negedge clk); #1;
        pc0 = press_count;
        sw = 4'hE;
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        btn_enter = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        #1;
        n_cmp++;
        if (press_count !== pc0) begin
            n_bad++;
            $display("FAIL glitch_press: got %0d pulses, expected 0", press_count - pc0);
        end
        n_cmp++;
        if (observed() !== m) begin
            n_bad++;
            $display("FAIL glitch_state: got %h, expected %h", observed(), m);
        end
`else
        // Without debounce a single synchronised high cycle is a real press.
        enter(4'h6, 1);
`endif
    endtask

    task automatic test_load_a();
        do_reset();
        enter(4'h5, 12);
    endtask

    task automatic test_full_sequence();
        do_reset();
        enter(4'h3, 12);
        enter(4'h9, 12);
        enter(4'b0110, 12);
        n_cmp++;
        if (op_type !== 1'b1 || select !== 2'b10 || valid !== 1'b1 || phase !== 2'b11) begin
            n_bad++;
            $display("FAIL op_fields: got t=%b sel=%b v=%b ph=%b, expected t=1 sel=10 v=1 ph=11",
                     op_type, select, valid, phase);
        end
    endtask

    task automatic test_show_press();
        enter(4'h0, 12);
        n_cmp++;
        if (A !== 4'h3 || B !== 4'h9 || valid !== 1'b0 || phase !== 2'b00) begin
            n_bad++;
            $display("FAIL show_retain: got A=%h B=%h v=%b ph=%b, expected A=3 B=9 v=0 ph=00",
                     A, B, valid, phase);
        end
        enter(4'hC, 5);
    endtask

    task automatic test_reset_in_load_op();
        enter(4'h7, 12);
        @(negedge clk); #1;
        reset = 1'b1;
        btn_enter = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (observed() !== obs_t'(0) || press !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_load_op: got %h press=%b, expected 0000 press=0", observed(), press);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_override_hold();
        obs_t exp_v;
        @(negedge clk); #1;
        sw = 4'hA;
        btn_enter = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        #1;
        n_cmp++;
        if (press !== 1'b1) begin
            n_bad++;
            $display("FAIL override_setup: press=%b, expected 1", press);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (observed() !== obs_t'(0) || press !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_override: got %h press=%b, expected 0000 press=0", observed(), press);
        end
        reset = 1'b0;
        model_reset();
        apply_model(4'hA);
        sb.push_back(m);
        for (int e = 1; e <= LAT; e++) begin
            @(negedge clk); #1;
            if (e == LAT - 1) begin
                n_cmp++;
                if (press !== 1'b1 || phase !== 2'b00) begin
                    n_bad++;
                    $display("FAIL held_repress: press=%b phase=%b, expected press=1 phase=00", press, phase);
                end
            end
            if (e == LAT) begin
                exp_v = (sb.size() > 0) ? sb.pop_front() : '1;
                n_cmp++;
                if (observed() !== exp_v) begin
                    n_bad++;
                    $display("FAIL held_capture: got %h, expected %h", observed(), exp_v);
                end
            end
        end
        btn_enter = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_load_a();
        test_full_sequence();
        test_show_press();
        test_reset_in_load_op();
        test_reset_override_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
